// File: rtl/universal_register_if.sv
// Bus bundle for universal_register: load/start request side plus register outputs.
interface universal_register_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH+1)
);
  logic             ld;
  logic [WIDTH-1:0] d;
  logic             start;
  logic [2:0]       mode;
  logic [AMT_W-1:0] amt;
  logic             si;
  logic [WIDTH-1:0] q;
  logic             cout;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (output ld, d, start, mode, amt, si,
                  input  q, cout, zero, busy, done);
  modport slave  (input  ld, d, start, mode, amt, si,
                  output q, cout, zero, busy, done);
endinterface

// File: rtl/universal_register.sv
// WIDTH-bit register with parallel load and multi-cycle shift/rotate/count
// operations, sequenced by a start/busy/done handshake.
module universal_register #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               AMT_W   = $clog2(WIDTH+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  universal_register_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_e;
  typedef enum logic [2:0] {
    OP_NOP, OP_SHL, OP_SHR, OP_ASR, OP_ROL, OP_ROR, OP_INC, OP_DEC
  } op_e;

  state_e           state_q, state_d;
  op_e              mode_q, mode_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_q;
  logic             step_c;

  // One step of the latched operation; si is taken live every step.
  always_comb begin
    step_q = q_q;
    step_c = cout_q;
    unique case (mode_q)
      OP_SHL: begin step_q = {q_q[WIDTH-2:0], bus.si};     step_c = q_q[WIDTH-1]; end
      OP_SHR: begin step_q = {bus.si, q_q[WIDTH-1:1]};     step_c = q_q[0];       end
      OP_ASR: begin step_q = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; step_c = q_q[0];     end
      OP_ROL: begin step_q = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; step_c = q_q[WIDTH-1]; end
      OP_ROR: begin step_q = {q_q[0], q_q[WIDTH-1:1]};     step_c = q_q[0];       end
      OP_INC: {step_c, step_q} = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};
      OP_DEC: begin step_q = q_q - {{(WIDTH-1){1'b0}}, 1'b1}; step_c = (q_q == '0); end
      default: begin step_q = q_q; step_c = cout_q; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ld) begin
          q_d    = bus.d;
          cout_d = 1'b0;
        end else if (bus.start) begin
          // A NOP or zero-length request completes at once without entering RUN.
          if (bus.mode != 3'd0 && bus.amt != '0) begin
            mode_d  = op_e'(bus.mode);
            cnt_d   = bus.amt;
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.ld) begin
          // Abort: no completion pulse for the dropped operation.
          q_d     = bus.d;
          cout_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          q_d    = step_q;
          cout_d = step_c;
          cnt_d  = cnt_q - {{(AMT_W-1){1'b0}}, 1'b1};
          if (cnt_q == {{(AMT_W-1){1'b0}}, 1'b1}) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= OP_NOP;
      cnt_q   <= '0;
      q_q     <= RST_VAL;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.cout = cout_q;
  assign bus.zero = (q_q == '0);
  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;

endmodule

// File: tb/tb_universal_register.sv
// Directed plus randomized checks of universal_register against an arithmetic model.
module tb_universal_register;
  localparam int W     = 8;
  localparam int AMT_W = $clog2(W+1);
  localparam int MASK  = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  universal_register_if #(.WIDTH(W), .AMT_W(AMT_W)) bus();

  universal_register #(.WIDTH(W), .RST_VAL('0), .AMT_W(AMT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int rq      = 0;   // model register value
  int rc      = 0;   // model cout

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_state(input string tag, input bit exp_busy, input bit exp_done);
    chk({tag, ".q"},    32'(bus.q),    32'(rq));
    chk({tag, ".cout"}, 32'(bus.cout), 32'(rc));
    chk({tag, ".zero"}, 32'(bus.zero), 32'(rq == 0));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(exp_busy));
    chk({tag, ".done"}, 32'(bus.done), 32'(exp_done));
  endtask

  // Model of one operation step, written from the bit-level rules as arithmetic.
  function automatic void model_step(input int m, input int s);
    int msb, lsb;
    msb = (rq >> (W-1)) & 1;
    lsb = rq & 1;
    case (m)
      1: begin rc = msb; rq = ((rq << 1) | s) & MASK; end
      2: begin rc = lsb; rq = (rq >> 1) | (s << (W-1)); end
      3: begin rc = lsb; rq = (rq >> 1) | (msb << (W-1)); end
      4: begin rc = msb; rq = ((rq << 1) | msb) & MASK; end
      5: begin rc = lsb; rq = (rq >> 1) | (lsb << (W-1)); end
      6: begin rc = (rq == MASK); rq = (rq + 1) & MASK; end
      7: begin rc = (rq == 0);    rq = (rq + MASK) & MASK; end
      default: ;
    endcase
  endfunction

  task automatic do_load(input int v);
    bus.ld = 1'b1; bus.d = W'(v);
    tick();
    bus.ld = 1'b0;
    rq = v & MASK; rc = 0;
    chk_state("load", 1'b0, 1'b0);
  endtask

  // Runs one request; si_fix<0 means random si per step. Ends in the done cycle.
  task automatic do_op(input string tag, input int m, input int a, input int si_fix);
    int s;
    s = (si_fix < 0) ? int'($urandom_range(1)) : si_fix;
    bus.start = 1'b1; bus.mode = 3'(m); bus.amt = AMT_W'(a); bus.si = s[0];
    tick();
    if (m == 0 || a == 0) begin
      bus.start = 1'b0;
      chk_state({tag, ".degen"}, 1'b0, 1'b1);
      return;
    end
    chk_state({tag, ".accept"}, 1'b1, 1'b0);
    for (int i = 0; i < a; i++) begin
      // Request inputs change during RUN and must not disturb the latched op.
      bus.start = 1'($urandom_range(1));
      bus.mode  = 3'($urandom);
      bus.amt   = AMT_W'($urandom);
      s = (si_fix < 0) ? int'($urandom_range(1)) : si_fix;
      bus.si = s[0];
      tick();
      model_step(m, s);
      chk_state($sformatf("%s.step%0d", tag, i), i != a-1, i == a-1);
    end
    bus.start = 1'b0;
  endtask

  task automatic idle_tick(input string tag);
    tick();
    chk_state(tag, 1'b0, 1'b0);
  endtask

  initial begin
    bus.ld = 1'b0; bus.d = '0; bus.start = 1'b0; bus.mode = '0; bus.amt = '0; bus.si = 1'b0;

    // Reset state
    #1;
    rq = 0; rc = 0;
    chk_state("reset", 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;
    idle_tick("reset_rel");

    do_load(8'hA5);

    do_op("shl3", 1, 3, 0);
    chk("shl3.final_q", 32'(bus.q), 32'h28);
    chk("shl3.final_c", 32'(bus.cout), 32'h1);
    idle_tick("shl3.post");

    do_load(8'h80);
    do_op("asr2", 3, 2, 1);
    chk("asr2.final_q", 32'(bus.q), 32'hE0);
    idle_tick("asr2.post");

    do_load(8'h01);
    do_op("ror1", 5, 1, 0);
    chk("ror1.final_q", 32'(bus.q), 32'h80);
    idle_tick("ror1.post");

    do_load(8'hFF);
    do_op("inc1", 6, 1, 0);
    chk("inc1.zero", 32'(bus.zero), 32'h1);
    // back-to-back: start accepted in the done cycle
    do_op("dec2", 7, 2, 0);
    chk("dec2.final_q", 32'(bus.q), 32'hFE);
    chk("dec2.final_c", 32'(bus.cout), 32'h0);
    idle_tick("dec2.post");

    // Abort in RUN
    do_load(8'h81);
    bus.start = 1'b1; bus.mode = 3'd4; bus.amt = AMT_W'(5);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin tick(); model_step(4, 0); end
    chk("abort.mid_q", 32'(bus.q), 32'h06);
    bus.ld = 1'b1; bus.d = 8'h3C;
    tick();
    bus.ld = 1'b0; rq = 8'h3C; rc = 0;
    chk_state("abort.ld", 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle_tick("abort.nodone");

    // Degenerate requests
    do_op("amt0", 2, 0, 0);
    idle_tick("amt0.post");
    do_op("nop", 0, 3, 0);
    idle_tick("nop.post");

    // Async reset mid-operation
    do_load(8'h5A);
    bus.start = 1'b1; bus.mode = 3'd1; bus.amt = AMT_W'(4); bus.si = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    @(negedge clk); rst = 1'b0; #1;
    rq = 0; rc = 0;
    chk_state("arst", 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;
    idle_tick("arst.rel");
    do_load(8'h5A);
    do_op("arst.next", 1, 2, 1);
    idle_tick("arst.next.post");

    // Randomized operations, including amt > WIDTH and back-to-back starts
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = int'($urandom_range(9));
      if (kind == 0) do_load(int'($urandom_range(MASK)));
      else begin
        do_op($sformatf("rnd%0d", n), int'($urandom_range(7)),
              int'($urandom_range(W + 3)), -1);
        if (kind > 5) idle_tick($sformatf("rnd%0d.post", n));
      end
    end
    idle_tick("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/universal_register.md
Name: universal_register

Overview:
- Parametrised successor to the fixed 8-bit load-only register: a WIDTH-bit register with parallel load plus multi-cycle shift, rotate and count operations.
- A start/busy/done handshake runs each operation `amt` times, one step per clock.
- Datapath controllers use it for serial shifting, alignment and step counting without external shift logic.

Parameters:
- WIDTH, 8, data width in bits (≥2).
- RST_VAL, 0, value of q after reset.
- AMT_W, $clog2(WIDTH+1), width of the repeat-count input.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (rst=0 resets).
- ld  input  1  parallel load strobe; highest priority after reset.
- d  input  WIDTH  parallel load data.
- start  input  1  operation request; sampled only in IDLE.
- mode  input  3  operation: 0 NOP, 1 SHL, 2 SHR logical, 3 SHR arithmetic, 4 ROL, 5 ROR, 6 INC, 7 DEC.
- amt  input  AMT_W  number of steps.
- si  input  1  serial fill bit for SHL (into lsb) and SHR logical (into msb).
- q  output  WIDTH  register contents.
- cout  output  1  bit shifted/rotated out, or carry/borrow, of the most recent step.
- zero  output  1  combinational, equals (q==0).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse on operation completion.

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - q=RST_VAL, cout=0, busy=0, done=0, state=IDLE, step counter=0.
  - Release is synchronous to the next edge.
- States: IDLE and RUN. busy = (state==RUN). All outputs except zero are registered.
- IDLE, evaluated at each edge in priority order:
  - ld=1: q<=d, cout<=0, done<=0, start ignored.
  - start=1 with mode≠0 and amt≠0: latch mode, cnt<=amt, go to RUN; q unchanged this edge.
  - start=1 with mode=0 or amt=0: q unchanged, done<=1 next cycle, busy stays 0.
  - Otherwise: hold; done<=0.
- RUN: each edge applies one step of the latched mode and decrements cnt. mode/amt/start/si changes do not affect the latched operation; si is sampled live every step.
  - SHL: q<={q[W-2:0],si}, cout<=q[W-1].
  - SHR: q<={si,q[W-1:1]}, cout<=q[0].
  - ASR: q<={q[W-1],q[W-1:1]}, cout<=q[0].
  - ROL: q<={q[W-2:0],q[W-1]}, cout<=q[W-1].
  - ROR: q<={q[0],q[W-1:1]}, cout<=q[0].
  - INC: q<=q+1 modulo 2^W, cout<=(q was all ones).
  - DEC: q<=q-1 modulo 2^W, cout<=(q was 0).
  - On the step where cnt==1: go to IDLE, done<=1 for exactly the following cycle.
- Latency: start sampled at edge E0; steps occur at E1..E_amt; busy is high from after E0 until after E_amt; done is high from E_amt to E_amt+1.
- ld in RUN aborts the operation:
  - q<=d, cout<=0, go to IDLE.
  - No done pulse for the aborted operation.
- start in RUN is ignored; it is not queued.
- amt>WIDTH is legal: all amt steps run (e.g. logical shift with si=0 ends at 0; rotate wraps).
- Back-to-back operations: a start may be accepted in the cycle done is high, i.e. the first IDLE cycle.

Test Plan:
- Reset and load: rst=0 → q=0x00, busy=0, done=0, cout=0. Release rst, ld=1 with d=0xA5 → q=0xA5 after 1 edge, zero=0.
- Shift left: q=0xA5, start mode=1 amt=3 si=0 → busy for 3 cycles, q=0x4A, then 0x94, then 0x28, cout=1, single done pulse after the 3rd step.
- Arithmetic shift and rotate: q=0x80, ASR amt=2 → q=0xE0, cout=0. Then q=0x01, ROR amt=1 → q=0x80, cout=1.
- Counting wrap: q=0xFF, INC amt=1 → q=0x00, cout=1, zero=1. Then DEC amt=2 → q=0xFE, cout=0 (borrow only on the first step).
- Abort and degenerate request:
  - ROL amt=5 on 0x81; after 2 steps (q=0x06) assert ld with d=0x3C → q=0x3C, busy=0, no done.
  - start with amt=0 → done pulses once, q unchanged, busy never high.
- Async reset mid-operation: SHL amt=4 in progress; drop rst between clock edges → q=RST_VAL, busy=0 immediately without a clock edge. After release, the next start is accepted normally.
